dot_product_accumulator: RTL and testbench

DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

---
 rtl/dot_product_accumulator.sv | 92 +++++++++
 tb/tb_dot_product_accumulator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Sums VECTOR_LENGTH unsigned products per dot product and queues completed
// sums in a small FIFO. A sum that arrives at a full FIFO with no pop is dropped.
module dot_product_accumulator #(
    parameter  int PRODUCT_WIDTH = 16,
    parameter  int VECTOR_LENGTH = 8,
    parameter  int FIFO_DEPTH    = 4,
    localparam int SUM_WIDTH     = PRODUCT_WIDTH + $clog2(VECTOR_LENGTH),
    localparam int COUNT_WIDTH   = $clog2(VECTOR_LENGTH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_product_valid,
    input  logic [PRODUCT_WIDTH-1:0] i_product,
    input  logic                     i_flush,
    output logic                     o_sum_valid,
    input  logic                     i_sum_ready,
    output logic [SUM_WIDTH-1:0]     o_sum,
    output logic [COUNT_WIDTH-1:0]   o_element_count,
    output logic                     o_drop,
    output logic                     o_overflow
);
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    logic [SUM_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] count;
    logic [SUM_WIDTH-1:0]   product_ext;
    logic                   last;
    logic [SUM_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]    wr_ptr, rd_ptr;
    logic                   empty, full, pop, push, dropping;
    logic                   drop, overflow;

    assign product_ext = {{(SUM_WIDTH-PRODUCT_WIDTH){1'b0}}, i_product};
    // A flush wins over completion: the product restarts a vector instead.
    assign last = i_product_valid && !i_flush && (count == COUNT_WIDTH'(VECTOR_LENGTH - 1));

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign pop      = !empty && i_sum_ready;
    assign push     = last && (!full || pop);
    assign dropping = last && full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc   <= '0;
            count <= '0;
        end else if (i_flush) begin
            acc   <= i_product_valid ? product_ext : '0;
            count <= i_product_valid ? COUNT_WIDTH'(1) : '0;
        end else if (i_product_valid) begin
            if (last) begin
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= acc + product_ext;
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= acc + product_ext;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            drop     <= dropping;
            overflow <= overflow | dropping;
        end
    end

    assign o_sum_valid     = !empty;
    assign o_sum           = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign o_element_count = count;
    assign o_drop          = drop;
    assign o_overflow      = overflow;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed and random stimulus for dot_product_accumulator, checked against a
// queue-based reference model of vectors and the completed-sum buffer.
module tb_dot_product_accumulator;
    localparam int PW = 16;
    localparam int VL = 8;
    localparam int DEPTH = 4;
    localparam int SW = PW + $clog2(VL);
    localparam int CW = $clog2(VL);

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_product_valid = 1'b0;
    logic [PW-1:0] i_product = '0;
    logic          i_flush = 1'b0;
    logic          i_sum_ready = 1'b0;
    logic          o_sum_valid;
    logic [SW-1:0] o_sum;
    logic [CW-1:0] o_element_count;
    logic          o_drop;
    logic          o_overflow;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int unsigned   vec[$];
    logic [SW-1:0] fifo[$];
    bit            exp_drop = 0;
    bit            exp_ovf = 0;

    dot_product_accumulator #(.PRODUCT_WIDTH(PW), .VECTOR_LENGTH(VL), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_product_valid(i_product_valid),
        .i_product(i_product), .i_flush(i_flush), .o_sum_valid(o_sum_valid),
        .i_sum_ready(i_sum_ready), .o_sum(o_sum), .o_element_count(o_element_count),
        .o_drop(o_drop), .o_overflow(o_overflow));

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input int unsigned p, input bit f, input bit r, input bit rst);
        bit popping, pushing;
        logic [SW-1:0] s;
        if (rst) begin
            vec.delete(); fifo.delete(); exp_drop = 0; exp_ovf = 0;
            return;
        end
        popping = (fifo.size() != 0) && r;
        pushing = 0;
        s = '0;
        if (f) begin
            vec.delete();
            if (v) vec.push_back(p);
        end else if (v) begin
            vec.push_back(p);
            if (vec.size() == VL) begin
                foreach (vec[i]) s += SW'(vec[i]);
                vec.delete();
                pushing = 1;
            end
        end
        exp_drop = 0;
        if (popping) void'(fifo.pop_front());
        if (pushing) begin
            if (fifo.size() < DEPTH) fifo.push_back(s);
            else begin exp_drop = 1; exp_ovf = 1; end
        end
    endtask

    // Apply inputs for one cycle, advance the model across the edge, check all outputs.
    task automatic step(input bit v, input int unsigned p, input bit f, input bit r, input bit rst);
        i_product_valid = v; i_product = PW'(p); i_flush = f; i_sum_ready = r; i_reset = rst;
        @(posedge i_clk);
        #1;
        model_edge(v, p, f, r, rst);
        chk("sum_valid", 64'(o_sum_valid), 64'(fifo.size() != 0));
        if (fifo.size() != 0) chk("sum", 64'(o_sum), 64'(fifo[0]));
        chk("count", 64'(o_element_count), 64'(vec.size()));
        chk("drop", 64'(o_drop), 64'(exp_drop));
        chk("overflow", 64'(o_overflow), 64'(exp_ovf));
    endtask

    initial begin
        bit v, f, r, rst;
        int unsigned p;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_sum", 64'(o_sum), 64'd0);
        step(0, 0, 0, 1, 0);

        // Products 1..8, consumer ready
        for (int k = 1; k <= VL; k++) step(1, k, 0, 1, 0);
        chk("sum36", 64'(o_sum), 64'd36);
        chk("sum36_count", 64'(o_element_count), 64'd0);
        step(0, 0, 0, 1, 0);
        chk("sum36_gone", 64'(o_sum_valid), 64'd0);

        // Maximum products: no truncation
        for (int k = 0; k < VL; k++) step(1, 16'hFFFF, 0, 0, 0);
        chk("max_sum", 64'(o_sum), 64'h7FFF8);
        step(0, 0, 0, 0, 0);
        chk("max_hold", 64'(o_sum), 64'h7FFF8);
        step(0, 0, 0, 1, 0);

        // Five vectors of ones with no consumer: fifth dropped
        for (int n = 0; n < 5; n++)
            for (int k = 0; k < VL; k++) step(1, 1, 0, 0, 0);
        chk("drop_pulse", 64'(o_drop), 64'd1);
        step(0, 0, 0, 0, 0);
        chk("drop_once", 64'(o_drop), 64'd0);
        chk("ovf_sticky", 64'(o_overflow), 64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_val", 64'(o_sum), 64'd8);
            step(0, 0, 0, 1, 0);
        end
        chk("drained", 64'(o_sum_valid), 64'd0);

        // Full FIFO with a pop on the completing edge: push accepted
        for (int n = 0; n < DEPTH; n++)
            for (int k = 0; k < VL; k++) step(1, n + 2, 0, 0, 0);
        for (int k = 0; k < VL - 1; k++) step(1, 9, 0, 0, 0);
        step(1, 9, 0, 1, 0);
        chk("full_push_nodrop", 64'(o_drop), 64'd0);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 1, 0);

        // Flush carrying a product restarts the vector
        for (int k = 0; k < 3; k++) step(1, 5, 0, 1, 0);
        step(1, 7, 1, 1, 0);
        chk("flush_count", 64'(o_element_count), 64'd1);
        for (int k = 0; k < VL - 1; k++) step(1, 1, 0, 0, 0);
        chk("flush_sum", 64'(o_sum), 64'd14);
        step(0, 0, 1, 1, 0);

        // Reset mid-vector with two sums buffered, competing with product/flush/pop
        for (int k = 0; k < 2 * VL + 3; k++) step(1, k, 0, 0, 0);
        step(1, 3, 1, 1, 1);
        chk("rst_valid", 64'(o_sum_valid), 64'd0);
        chk("rst_count", 64'(o_element_count), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        for (int k = 1; k <= VL; k++) step(1, 10 * k, 0, 0, 0);
        chk("post_rst_sum", 64'(o_sum), 64'd360);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 599) == 0);
            case ($urandom_range(0, 3))
                0: p = 16'hFFFF;
                1: p = 0;
                default: p = $urandom_range(0, 65535);
            endcase
            step(v, p, f, r, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
